// File: rtl/dram_ld_ctrl.sv
// dram_ld_ctrl: DRAM-to-SRAM load controller.
// Accepts one load command, issues a single AXI INCR read burst, then packs
// pairs of 64-bit read beats into 128-bit SRAM lines at consecutive line addresses.
// A trailing odd beat is written as a zero-extended half line.
// The optional read-ID check is enabled by defining DRAM_LD_CTRL_RID_CHK_EN.
// When it is enabled, beats whose rid does not match the command id are dropped and flagged.
// Reset input rst_n is synchronous and active-high despite its name.
module dram_ld_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_vld,
    input  logic [7:0]   cmd_id,
    input  logic [30:0]  cmd_dram_addr,
    input  logic [7:0]   cmd_len,
    input  logic [2:0]   cmd_size,
    input  logic [11:0]  cmd_sram_addr,
    input  logic [1:0]   cmd_sram_type,
    output logic         cmd_rdy,
    output logic [7:0]   ld_axi_arid,
    output logic [30:0]  ld_axi_araddr,
    output logic [7:0]   ld_axi_arlen,
    output logic [2:0]   ld_axi_arsize,
    output logic [1:0]   ld_axi_arburst,
    output logic         ld_axi_arvld,
    input  logic         axi_ld_arrdy,
    input  logic [7:0]   axi_ld_rid,
    input  logic [63:0]  axi_ld_rdata,
    input  logic [1:0]   axi_ld_rresp,
    input  logic         axi_ld_rlast,
    input  logic         axi_ld_rvld,
    output logic         ld_axi_rrdy,
    output logic         ld_sram_cen,
    output logic         ld_sram_wen,
    output logic [7:0]   ld_sram_addr,
    output logic [127:0] ld_sram_din,
    output logic [1:0]   ld_sram_type,
    output logic         ld_done,
    output logic         ld_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // Registered command fields
    logic [7:0]   id_reg;
    logic [30:0]  dram_addr_reg;
    logic [7:0]   len_reg;
    logic [2:0]   size_reg;
    logic [1:0]   type_reg;
    logic [7:0]   line_reg;

    // Beat tracking; bit 0 of the beat counter is the half-line flag
    logic [7:0]   beat_cnt_reg;
    logic [63:0]  hold_reg;
    logic         err_reg;

    // Registered SRAM write port
    logic         sram_cen_reg;
    logic [7:0]   sram_addr_reg;
    logic [127:0] sram_din_reg;
    logic [1:0]   sram_type_reg;

    logic cmd_fire;
    logic ar_fire;
    logic beat_fire;
    logic beat_valid;
    logic beat_use;

    assign cmd_fire  = cmd_vld & cmd_rdy;
    assign ar_fire   = ld_axi_arvld & axi_ld_arrdy;
    assign beat_fire = axi_ld_rvld & ld_axi_rrdy;

`ifdef DRAM_LD_CTRL_RID_CHK_EN
    // Only beats carrying our own id contribute data, count and rlast
    assign beat_valid = (axi_ld_rid == id_reg);
`else
    logic rid_unused;
    assign rid_unused = ^axi_ld_rid;
    assign beat_valid = 1'b1;
`endif

    assign beat_use = beat_fire & beat_valid;

    // State register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cmd_fire) state_next = ADDR;
            ADDR:    if (ar_fire) state_next = DATA;
            DATA:    if (beat_use && axi_ld_rlast) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs; AR payload is forced to zero outside ADDR
    always_comb begin
        cmd_rdy        = (state_reg == IDLE);
        ld_axi_arvld   = (state_reg == ADDR);
        ld_axi_rrdy    = (state_reg == DATA);
        ld_done        = (state_reg == DONE);
        ld_err         = (state_reg == DONE) ? err_reg : 1'b0;
        ld_axi_arid    = ld_axi_arvld ? id_reg : 8'd0;
        ld_axi_araddr  = ld_axi_arvld ? dram_addr_reg : 31'd0;
        ld_axi_arlen   = ld_axi_arvld ? len_reg : 8'd0;
        ld_axi_arsize  = ld_axi_arvld ? size_reg : 3'd0;
        ld_axi_arburst = ld_axi_arvld ? 2'b01 : 2'b00;
        ld_sram_cen    = sram_cen_reg;
        ld_sram_wen    = sram_cen_reg;
        ld_sram_addr   = sram_addr_reg;
        ld_sram_din    = sram_din_reg;
        ld_sram_type   = sram_type_reg;
    end

    // Command capture, beat packing, error accumulation and SRAM write staging
    always_ff @(posedge clk) begin
        if (rst_n) begin
            id_reg        <= 8'd0;
            dram_addr_reg <= 31'd0;
            len_reg       <= 8'd0;
            size_reg      <= 3'd0;
            type_reg      <= 2'd0;
            line_reg      <= 8'd0;
            beat_cnt_reg  <= 8'd0;
            hold_reg      <= 64'd0;
            err_reg       <= 1'b0;
            sram_cen_reg  <= 1'b0;
            sram_addr_reg <= 8'd0;
            sram_din_reg  <= 128'd0;
            sram_type_reg <= 2'd0;
        end else begin
            // The write port is a one-cycle strobe; idle value is all zero
            sram_cen_reg  <= 1'b0;
            sram_addr_reg <= 8'd0;
            sram_din_reg  <= 128'd0;
            sram_type_reg <= 2'd0;

            if (cmd_fire) begin
                id_reg        <= cmd_id;
                dram_addr_reg <= cmd_dram_addr;
                len_reg       <= cmd_len;
                size_reg      <= cmd_size;
                type_reg      <= cmd_sram_type;
                line_reg      <= cmd_sram_addr[11:4];
                beat_cnt_reg  <= 8'd0;
                hold_reg      <= 64'd0;
                err_reg       <= 1'b0;
            end

            // Error responses and foreign-id beats are sticky errors
            if (beat_fire && ((axi_ld_rresp != 2'b00) || !beat_valid)) begin
                err_reg <= 1'b1;
            end

            if (beat_use) begin
                // Burst length must agree with the rlast position
                if (axi_ld_rlast && (beat_cnt_reg != len_reg)) begin
                    err_reg <= 1'b1;
                end
                if (!axi_ld_rlast && (beat_cnt_reg == len_reg)) begin
                    err_reg <= 1'b1;
                end
                beat_cnt_reg <= beat_cnt_reg + 8'd1;

                if (beat_cnt_reg[0]) begin
                    // Odd beat completes a line; earlier beat in the low half
                    sram_cen_reg  <= 1'b1;
                    sram_addr_reg <= line_reg;
                    sram_din_reg  <= {axi_ld_rdata, hold_reg};
                    sram_type_reg <= type_reg;
                    line_reg      <= line_reg + 8'd1;
                end else if (axi_ld_rlast) begin
                    // Burst ended on an even beat: flush a half line
                    sram_cen_reg  <= 1'b1;
                    sram_addr_reg <= line_reg;
                    sram_din_reg  <= {64'd0, axi_ld_rdata};
                    sram_type_reg <= type_reg;
                    line_reg      <= line_reg + 8'd1;
                end else begin
                    hold_reg <= axi_ld_rdata;
                end
            end
        end
    end

endmodule
